snapshot_streamer: RTL
======================

SNAPSHOT_STREAMER -- requirements
Module: snapshot_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 176: bit width of the captured state vector, minimum 1.
REQ-002 SHALL have parameter HEADER, default 8'hF0: start byte sent before each snapshot.
REQ-003 SHALL have parameter ON_CHANGE, default 0: when 1, a pulse whose state equals the last sent snapshot is skipped.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pulse_i  input  1  capture request.
REQ-007 SHALL have port state_i  input  WIDTH  vector sampled on an accepted pulse.
REQ-008 SHALL have port write_o  output  1  data_o valid.
REQ-009 SHALL have port data_o  output  8  current byte.
REQ-010 SHALL have port hold_i  input  1  sink backpressure; byte not consumed while high.
REQ-011 SHALL have port busy_o  output  1  snapshot in progress; equals write_o.
REQ-012 SHALL have port dropped_o  output  8  count of pulses ignored while busy, saturating at 255.

Function
REQ-013 SHALL define NBYTES = ceil(WIDTH/8); frame = HEADER, then NBYTES data bytes LSB-first, upper pad bits zero.
REQ-014 SHALL implement states IDLE and SEND; IDLE->SEND on accepted pulse; SEND->IDLE when last frame byte is consumed.
REQ-015 SHALL consume a byte in a cycle with write_o=1 and hold_i=0; data_o and write_o SHALL stay stable while hold_i=1.
REQ-016 SHALL assert write_o with data_o=HEADER in the cycle after an accepted pulse (latency 1).
REQ-017 SHALL sample state_i only in the accepting cycle; later state_i changes SHALL not affect the frame.
REQ-018 SHALL ignore pulse_i in SEND and increment dropped_o, saturating at 8'hFF.
REQ-019 SHALL accept a pulse in the cycle the last byte is consumed, keeping write_o high next cycle with HEADER (back-to-back frames, no gap).
REQ-020 SHALL, when ON_CHANGE=1, compare state_i to the last sent snapshot and, if equal, neither send nor count a drop.
REQ-021 SHALL, when ON_CHANGE=1, always send the first pulse after reset.
REQ-022 SHALL drive data_o=8'h00 while write_o=0.
REQ-023 SHALL keep the byte counter at $clog2(frame length) bits with no wrap beyond the final byte.

Reset
REQ-024 SHALL, on reset=1, force IDLE, write_o=0, data_o=0, dropped_o=0, and clear the last-sent record, one cycle after the asserting edge.
REQ-025 SHALL abandon a frame in progress on reset, with no further bytes emitted.
REQ-026 SHALL ignore pulse_i in any cycle where reset=1.

Configuration
REQ-027 SHALL, with SNAPSHOT_STREAMER_CHECKSUM_EN defined, append one trailer byte equal to the XOR of all NBYTES data bytes (HEADER excluded).
REQ-028 SHALL, without SNAPSHOT_STREAMER_CHECKSUM_EN, end the frame after the last data byte, with no checksum logic present.

Structure
REQ-029 SHALL take the default HEADER constant and an NBYTES helper function from shared package bringup_pkg.
REQ-030 SHALL place the checksum in sub-module snapshot_xor8 (byte-wide XOR accumulator with clear/enable), instantiated only under the macro.

Verification
REQ-031 SHALL cover: WIDTH=16, hold_i=0, pulse with state 16'hA55A -> bytes F0,5A,A5 on 3 consecutive cycles, plus FF with CHECKSUM_EN.
REQ-032 SHALL cover: WIDTH=12, state 12'hABC -> F0,BC,0A (pad zero); hold_i high 3 cycles on byte BC -> BC held stable for 3 cycles, no loss.
REQ-033 SHALL cover: 300 pulses while busy -> dropped_o saturates at 255; frame content unchanged.
REQ-034 SHALL cover: pulse coincident with last-byte consumption -> next cycle write_o=1, data_o=F0, no idle gap.
REQ-035 SHALL cover: ON_CHANGE=1, pulses with states 1,1,2 -> two frames only; dropped_o stays 0.
REQ-036 SHALL cover: reset asserted mid-frame after byte 1 -> write_o=0 next cycle; next pulse yields a full frame starting F0.

Source files
------------

// File: rtl/bringup_pkg.sv
// Shared bring-up definitions for snapshot_streamer and related debug blocks.
// Contents:
//   DefaultHeader  - default frame start byte
//   stream_state_e - two-state streamer FSM encoding
//   nbytes()       - number of whole bytes needed to hold a vector of given width
package bringup_pkg;

   localparam logic [7:0] DefaultHeader = 8'hF0;

   typedef enum logic {
      StIdle,
      StSend
   } stream_state_e;

   function automatic int unsigned nbytes(input int unsigned width);
      return (width + 32'd7) / 32'd8;
   endfunction

endpackage

// File: rtl/snapshot_xor8.sv
// Byte-wide XOR accumulator used to build the snapshot trailer checksum.
// Ports:
//   clk_i  - clock (rising edge)
//   rst_i  - synchronous active-high reset
//   clr_i  - restart accumulation at zero (wins over en_i)
//   en_i   - fold data_i into the accumulator
//   data_i - byte to fold in
//   acc_o  - current accumulator value
module snapshot_xor8 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [7:0] data_i,
   output logic [7:0] acc_o
);

   logic [7:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = 8'h00;
      end else if (en_i) begin
         acc_d = acc_q ^ data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= 8'h00;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/snapshot_streamer.sv
// Captures a WIDTH-bit state vector on a pulse and streams it out as a byte frame:
// HEADER, then ceil(WIDTH/8) data bytes LSB-first (pad bits zero).
// Optional: define SNAPSHOT_STREAMER_CHECKSUM_EN to append an XOR trailer byte over
// the data bytes.
// Ports:
//   clock     - sole clock, rising edge
//   reset     - synchronous active-high reset
//   pulse_i   - capture request
//   state_i   - vector sampled on an accepted pulse
//   write_o   - data_o valid
//   data_o    - current frame byte (0 when idle)
//   hold_i    - sink backpressure; byte not consumed while high
//   busy_o    - frame in progress (same as write_o)
//   dropped_o - pulses ignored while busy, saturating at 255
module snapshot_streamer
   import bringup_pkg::*;
#(
   parameter int unsigned WIDTH     = 176,
   parameter logic [7:0]  HEADER    = DefaultHeader,
   parameter bit          ON_CHANGE = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             pulse_i,
   input  logic [WIDTH-1:0] state_i,
   output logic             write_o,
   output logic [7:0]       data_o,
   input  logic             hold_i,
   output logic             busy_o,
   output logic [7:0]       dropped_o
);

   localparam int unsigned NBytes = nbytes(WIDTH);
   localparam int unsigned PadW   = NBytes * 8;
`ifdef SNAPSHOT_STREAMER_CHECKSUM_EN
   localparam int unsigned FrameLen = NBytes + 2;
`else
   localparam int unsigned FrameLen = NBytes + 1;
`endif
   localparam int unsigned    CntW    = (FrameLen > 1) ? $clog2(FrameLen) : 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);

   stream_state_e    state_q, state_d;
   logic [CntW-1:0]  idx_q, idx_d;
   logic [PadW-1:0]  snap_q, snap_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             last_valid_q, last_valid_d;
   logic [7:0]       dropped_q, dropped_d;

   logic consume, last_consume, skip, can_accept, accept, drop;
   logic [7:0] snap_byte;

   always_comb begin
      consume      = (state_q == StSend) && !hold_i;
      last_consume = consume && (idx_q == LastIdx);
      // Unchanged snapshots are silently discarded: no frame and no drop count.
      skip         = ON_CHANGE && last_valid_q && (state_i == last_q);
      // The final byte's consume cycle also accepts, giving back-to-back frames.
      can_accept   = (state_q == StIdle) || last_consume;
      accept       = pulse_i && can_accept && !skip;
      drop         = pulse_i && !can_accept && !skip;
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      snap_d       = snap_q;
      last_d       = last_q;
      last_valid_d = last_valid_q;
      dropped_d    = dropped_q;

      if (accept) begin
         state_d      = StSend;
         idx_d        = '0;
         snap_d       = PadW'(state_i);
         last_d       = state_i;
         last_valid_d = 1'b1;
      end else if (last_consume) begin
         state_d = StIdle;
         idx_d   = '0;
      end else if (consume) begin
         idx_d = idx_q + 1'b1;
      end

      if (drop && (dropped_q != 8'hFF)) begin
         dropped_d = dropped_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         snap_q       <= '0;
         last_q       <= '0;
         last_valid_q <= 1'b0;
         dropped_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         snap_q       <= snap_d;
         last_q       <= last_d;
         last_valid_q <= last_valid_d;
         dropped_q    <= dropped_d;
      end
   end

   // Frame index 1..NBytes maps to snapshot byte 0..NBytes-1.
   always_comb begin
      snap_byte = 8'h00;
      for (int unsigned b = 0; b < NBytes; b++) begin
         if (idx_q == CntW'(b + 1)) begin
            snap_byte = snap_q[b*8 +: 8];
         end
      end
   end

`ifdef SNAPSHOT_STREAMER_CHECKSUM_EN
   logic       csum_en;
   logic [7:0] csum;

   // Fold each data byte as it leaves; header and trailer are excluded.
   assign csum_en = consume && (idx_q != '0) && (idx_q != LastIdx);

   snapshot_xor8 u_xor (
      .clk_i  (clock),
      .rst_i  (reset),
      .clr_i  (accept),
      .en_i   (csum_en),
      .data_i (snap_byte),
      .acc_o  (csum)
   );
`endif

   always_comb begin
      data_o = 8'h00;
      if (state_q == StSend) begin
         if (idx_q == '0) begin
            data_o = HEADER;
`ifdef SNAPSHOT_STREAMER_CHECKSUM_EN
         end else if (idx_q == LastIdx) begin
            data_o = csum;
`endif
         end else begin
            data_o = snap_byte;
         end
      end
   end

   assign write_o   = (state_q == StSend);
   assign busy_o    = write_o;
   assign dropped_o = dropped_q;

endmodule
